// File: rtl/multiplier_unit_cu_if.sv
// -----------------------------------------------------------------------------
// multiplier_unit_cu_if
//   Operand/result handshake bundle between a requester and the multiplier
//   control unit.
//
//   in_valid    requester offers an operand pair
//   in_ready    control unit can accept an operand pair
//   in_usigned  1 = unsigned multiply, 0 = signed multiply
//   in_a        multiplier operand
//   in_b        multiplicand operand
//   out_valid   datapath product register holds the result
//   out_ready   requester accepts the result
//
//   master : requester side
//   slave  : control unit side
// -----------------------------------------------------------------------------
interface multiplier_unit_cu_if #(
    parameter int PARALLELISM = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_usigned;
    logic [PARALLELISM-1:0] in_a;
    logic [PARALLELISM-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_valid,
        output in_usigned,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in_usigned,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/multiplier_unit_cu.sv
// -----------------------------------------------------------------------------
// multiplier_unit_cu
//   Control unit for the radix-2 carry-save multiplier datapath
//   (MultiplierUnitDP). Accepts one operand pair at a time, holds the operands
//   stable for the datapath, sequences every datapath strobe from a Moore FSM
//   and returns the result through a valid/ready handshake. A watchdog moves
//   the controller into a sticky error state if the datapath terminal count
//   never arrives.
//
// Parameters
//   PARALLELISM  operand width, must match the datapath
//   MAX_ITER     watchdog limit on ITER cycles (> 32)
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset
//   bus (slave)          in_valid/in_ready/in_usigned/in_a/in_b,
//                        out_valid/out_ready
//   err                  sticky watchdog error
//   usigned              registered signedness select to the datapath
//   multiplier           registered multiplier operand to the datapath
//   multiplicand         registered multiplicand operand to the datapath
//   csa_clear .. prod_en datapath strobes
//   tc                   datapath terminal count (only observed in ITER)
//   abort                optional, present when MULT_CU_ABORT_EN is defined:
//                        cancels an operation in CLEAR..FINAL
//
// Build option
//   MULT_CU_ABORT_EN     adds the abort input port
// -----------------------------------------------------------------------------
module multiplier_unit_cu #(
    parameter int PARALLELISM = 32,
    parameter int MAX_ITER    = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    multiplier_unit_cu_if.slave    bus,
    output logic                   err,
    output logic                   usigned,
    output logic [PARALLELISM-1:0] multiplier,
    output logic [PARALLELISM-1:0] multiplicand,
    output logic                   csa_clear,
    output logic                   multiplicand_en,
    output logic                   notMultiplicand_en,
    output logic                   sumMux_sel,
    output logic                   sum_en,
    output logic                   carry_en,
    output logic                   leftAddMux_sel,
    output logic                   count_en,
    output logic                   prod_en,
    input  logic                   tc
`ifdef MULT_CU_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    localparam int WD_W = $clog2(MAX_ITER);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] LOADM = 3'd2;
    localparam logic [2:0] FIRST = 3'd3;
    localparam logic [2:0] ITER  = 3'd4;
    localparam logic [2:0] FINAL = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;
    localparam logic [2:0] ERR   = 3'd7;

    logic [2:0]      state;
    logic [2:0]      stateNext;
    logic            armed;
    logic [WD_W-1:0] wdCount;
    logic            accept;
    logic            abortReq;
    logic            wdExpired;

`ifdef MULT_CU_ABORT_EN
    assign abortReq = abort;
`else
    assign abortReq = 1'b0;
`endif

    // The state register resets to IDLE, but in_ready must stay low while rst
    // is asserted; armed holds it off until the first edge after release.
    assign bus.in_ready  = (state == IDLE) && armed;
    assign bus.out_valid = (state == DONE);
    assign err           = (state == ERR);

    assign accept    = (state == IDLE) && armed && bus.in_valid;
    assign wdExpired = (wdCount == WD_W'(MAX_ITER - 1));

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (accept) stateNext = CLEAR;
            CLEAR: stateNext = abortReq ? IDLE : LOADM;
            LOADM: stateNext = abortReq ? IDLE : FIRST;
            FIRST: stateNext = abortReq ? IDLE : ITER;
            ITER: begin
                // abort outranks tc, tc outranks the watchdog
                if (abortReq)       stateNext = IDLE;
                else if (tc)        stateNext = FINAL;
                else if (wdExpired) stateNext = ERR;
                else                stateNext = ITER;
            end
            FINAL: stateNext = abortReq ? IDLE : DONE;
            DONE:  if (bus.out_ready) stateNext = IDLE;
            ERR:   stateNext = ERR;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            armed        <= 1'b0;
            wdCount      <= '0;
            usigned      <= 1'b0;
            multiplier   <= '0;
            multiplicand <= '0;
        end else begin
            state <= stateNext;
            armed <= 1'b1;
            if (accept) begin
                usigned      <= bus.in_usigned;
                multiplier   <= bus.in_a;
                multiplicand <= bus.in_b;
                wdCount      <= '0;
            end else if ((state == ITER) && !tc && !abortReq && !wdExpired) begin
                wdCount <= wdCount + WD_W'(1);
            end
        end
    end

    // Moore strobe decode: state only, never tc or abort.
    always_comb begin
        csa_clear          = 1'b0;
        multiplicand_en    = 1'b0;
        notMultiplicand_en = 1'b0;
        sumMux_sel         = 1'b0;
        sum_en             = 1'b0;
        carry_en           = 1'b0;
        leftAddMux_sel     = 1'b0;
        count_en           = 1'b0;
        prod_en            = 1'b0;
        case (state)
            CLEAR: csa_clear = 1'b1;
            LOADM: begin
                multiplicand_en    = 1'b1;
                notMultiplicand_en = 1'b1;
            end
            FIRST: sum_en = 1'b1;
            ITER: begin
                sumMux_sel     = 1'b1;
                sum_en         = 1'b1;
                carry_en       = 1'b1;
                leftAddMux_sel = 1'b1;
                count_en       = 1'b1;
            end
            FINAL: begin
                leftAddMux_sel = 1'b1;
                prod_en        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multiplier_unit_cu.sv
module tb_multiplier_unit_cu;

    localparam int P        = 32;
    localparam int MAX_ITER = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         err;
    logic         usigned;
    logic [P-1:0] multiplier;
    logic [P-1:0] multiplicand;
    logic         csa_clear;
    logic         multiplicand_en;
    logic         notMultiplicand_en;
    logic         sumMux_sel;
    logic         sum_en;
    logic         carry_en;
    logic         leftAddMux_sel;
    logic         count_en;
    logic         prod_en;
    logic         tc;
`ifdef MULT_CU_ABORT_EN
    logic         abort;
`endif

    multiplier_unit_cu_if #(.PARALLELISM(P)) bus ();

    multiplier_unit_cu #(
        .PARALLELISM(P),
        .MAX_ITER(MAX_ITER)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err(err),
        .usigned(usigned),
        .multiplier(multiplier),
        .multiplicand(multiplicand),
        .csa_clear(csa_clear),
        .multiplicand_en(multiplicand_en),
        .notMultiplicand_en(notMultiplicand_en),
        .sumMux_sel(sumMux_sel),
        .sum_en(sum_en),
        .carry_en(carry_en),
        .leftAddMux_sel(leftAddMux_sel),
        .count_en(count_en),
        .prod_en(prod_en),
        .tc(tc)
`ifdef MULT_CU_ABORT_EN
        ,
        .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] strobes;
    assign strobes = {csa_clear, multiplicand_en, notMultiplicand_en, sumMux_sel,
                      sum_en, carry_en, leftAddMux_sel, count_en, prod_en};

    // Reference product from plain arithmetic.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic us);
        longint sa;
        longint sb;
        if (us) return {32'b0, a} * {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Behavioural datapath: a terminal counter cleared by csa_clear and stepped
    // by count_en, and a product register loaded by prod_en.
    logic [5:0]  dpCnt    = '0;
    logic [63:0] dpProd   = '0;
    logic        tcEnable = 1'b1;
    always @(posedge clk) begin
        if (csa_clear)     dpCnt <= '0;
        else if (count_en) dpCnt <= dpCnt + 6'd1;
        if (prod_en) dpProd <= refProduct(multiplier, multiplicand, usigned);
    end
    assign tc = tcEnable && (dpCnt == 6'd31);

    // Expected strobes k cycles after the acceptance edge on a healthy run:
    // 1 clear, 2 load m, 3 first partial product, 4..35 iterate, 36 final.
    // Bit order: csa, m_en, notM_en, sumSel, sumEn, carryEn, leftSel, countEn, prodEn.
    function automatic logic [8:0] phaseStrobes(input int k);
        if (k == 1) return 9'b1_0000_0000;
        if (k == 2) return 9'b0_1100_0000;
        if (k == 3) return 9'b0_0001_0000;
        if (k >= 4 && k <= 35) return 9'b0_0011_1110;
        if (k == 36) return 9'b0_0000_0101;
        return 9'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_ctrl"}, 64'({strobes, bus.in_ready, bus.out_valid, err, usigned}), 64'(0));
        chk({tag, "_opnd"}, {multiplier, multiplicand}, 64'(0));
    endtask

    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic us,
                         input int bpCycles, input int abortAt);
        logic [63:0] expProd;
        int          waitCnt;
        expProd = refProduct(a, b, us);
        waitCnt = 0;
        while (bus.in_ready !== 1'b1 && waitCnt < 10) begin
            tick();
            waitCnt++;
        end
        chk("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
        bus.in_valid   = 1'b1;
        bus.in_a       = a;
        bus.in_b       = b;
        bus.in_usigned = us;
        bus.out_ready  = (bpCycles == 0);
        tick();
        bus.in_valid   = 1'b0;
        bus.in_a       = $urandom;
        bus.in_b       = $urandom;
        bus.in_usigned = 1'($urandom_range(0, 1));
        for (int k = 1; k <= 36; k++) begin
            chk($sformatf("ctrl_k%0d", k),
                64'({strobes, bus.in_ready, bus.out_valid, err, usigned}),
                64'({phaseStrobes(k), 3'b000, us}));
            chk($sformatf("opnd_k%0d", k), {multiplier, multiplicand}, {a, b});
            if (abortAt != 0 && k == abortAt) begin
`ifdef MULT_CU_ABORT_EN
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_idle", 64'({strobes, bus.in_ready, bus.out_valid, err}),
                    64'({9'h0, 3'b100}));
                for (int i = 0; i < 40; i++) begin
                    tick();
                    chk("abort_no_out_valid", 64'({strobes, bus.out_valid, err}), 64'(0));
                end
                bus.out_ready = 1'b0;
                return;
`endif
            end
            tick();
        end
        chk("done_ctrl", 64'({strobes, bus.in_ready, bus.out_valid, err}), 64'({9'h0, 3'b010}));
        chk("product", dpProd, expProd);
        for (int i = 0; i < bpCycles; i++) begin
            tick();
            chk("out_valid_held", 64'({strobes, bus.in_ready, bus.out_valid, err}),
                64'({9'h0, 3'b010}));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("idle_after_handshake", 64'({strobes, bus.in_ready, bus.out_valid, err}),
            64'({9'h0, 3'b100}));
        chk("opnd_held_after", {multiplier, multiplicand}, {a, b});
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_usigned = 1'b0;
        bus.out_ready  = 1'b0;
`ifdef MULT_CU_ABORT_EN
        abort = 1'b0;
`endif

        // Power-on reset
        tick();
        tick();
        checkAllZero("reset");
        bus.in_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk("in_ready_low_after_release", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b0;
        tick();
        chk("in_ready_first_cycle", 64'(bus.in_ready), 64'(1));

        // Signed -3 x 7
        runOp(32'hFFFF_FFFD, 32'd7, 1'b0, 0, 0);
        chk("signed_product_const", dpProd, 64'hFFFF_FFFF_FFFF_FFEB);

        // Unsigned max x max with 10 cycles of backpressure
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 10, 0);
        chk("unsigned_product_const", dpProd, 64'hFFFF_FFFE_0000_0001);

        // Randomized operations
        for (int i = 0; i < 4; i++) begin
            runOp($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
        end

        // Watchdog: tc never arrives
        tcEnable = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_a       = 32'h1234;
        bus.in_b       = 32'h5678;
        bus.in_usigned = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 3 + MAX_ITER; k++) begin
            chk($sformatf("wd_ctrl_k%0d", k),
                64'({strobes, bus.in_ready, bus.out_valid, err}),
                64'({(k <= 3) ? phaseStrobes(k) : 9'b0_0011_1110, 3'b000}));
            tick();
        end
        chk("wd_err", 64'({strobes, bus.in_ready, bus.out_valid, err}), 64'({9'h0, 3'b001}));
        tcEnable      = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wd_err_sticky", 64'({strobes, bus.in_ready, bus.out_valid, err}),
                64'({9'h0, 3'b001}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkAllZero("wd_reset");
        tick();
        rst = 1'b0;
        tick();

        // Reset during the 10th ITER cycle
        bus.in_valid   = 1'b1;
        bus.in_a       = 32'hDEAD_BEEF;
        bus.in_b       = 32'h0BAD_F00D;
        bus.in_usigned = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k < 13; k++) begin
            chk($sformatf("mid_ctrl_k%0d", k), 64'(strobes), 64'(phaseStrobes(k)));
            tick();
        end
        chk("mid_iter10", 64'(strobes), 64'(phaseStrobes(13)));
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("mid_reset_async");
        tick();
        rst = 1'b0;
        tick();
        runOp(32'd5, 32'd6, 1'b0, 0, 0);
        chk("after_reset_product", dpProd, 64'd30);

`ifdef MULT_CU_ABORT_EN
        // Abort in the 5th ITER cycle, then a clean 2 x 2
        runOp(32'd9, 32'd9, 1'b0, 0, 8);
        runOp(32'd2, 32'd2, 1'b0, 0, 0);
        chk("after_abort_product", dpProd, 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_unit_cu.md
Name: multiplier_unit_cu

Overview:
- Control unit for the radix-2 carry-save multiplier datapath (MultiplierUnitDP).
- Accepts one operand pair at a time over a valid/ready handshake and holds the operands stable for the datapath.
- Drives every datapath control strobe from an FSM and returns result-valid with a valid/ready handshake.
- Contains a watchdog that flags a datapath whose terminal count never arrives.

Parameters:
- PARALLELISM, 32, operand width; must match the datapath parallelism.
- MAX_ITER, 40, watchdog limit on ITER cycles; must be greater than 32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept an operand pair.
- in_usigned  in  1  1 selects unsigned multiply, 0 selects signed.
- in_a  in  PARALLELISM  multiplier operand.
- in_b  in  PARALLELISM  multiplicand operand.
- out_valid  out  1  product register in the datapath holds the result.
- out_ready  in  1  consumer accepts the result.
- err  out  1  sticky watchdog error.
- usigned, multiplier, multiplicand  out  1/PARALLELISM/PARALLELISM  registered operands driven to the datapath.
- csa_clear, multiplicand_en, notMultiplicand_en, sumMux_sel, sum_en, carry_en, leftAddMux_sel, count_en, prod_en  out  1 each  datapath strobes.
- tc  in  1  datapath terminal count.

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE.
  - All strobes, in_ready, out_valid and err are 0.
  - Operand registers are 0.
  - Watchdog count is 0.
  - in_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, CLEAR, LOADM, FIRST, ITER, FINAL, DONE, ERR.
- IDLE: in_ready=1.
  - If in_valid=1, the operands are captured, in_ready drops, and the next state is CLEAR.
  - Operands stay constant until the next acceptance.
- CLEAR: csa_clear=1. Clears the datapath registers and counter. Next state is LOADM.
- LOADM: multiplicand_en=1, notMultiplicand_en=1, leftAddMux_sel=0.
  - Loads m and -m.
  - Next state is FIRST.
- FIRST: sumMux_sel=0, sum_en=1, leftAddMux_sel=0.
  - Loads the first partial product.
  - Next state is ITER.
- ITER: sumMux_sel=1, sum_en=1, carry_en=1, count_en=1, leftAddMux_sel=1.
  - Strobes are asserted in every ITER cycle, including the cycle where tc=1.
  - tc=1 sends the next state to FINAL.
  - Otherwise the watchdog count increments.
  - When the watchdog count reaches MAX_ITER-1 with tc=0, the next state is ERR.
- FINAL: leftAddMux_sel=1, prod_en=1. Next state is DONE.
- DONE: out_valid=1.
  - out_ready=1 sends the next state to IDLE.
  - out_valid is held until the handshake completes.
  - There is no back-to-back acceptance from DONE; in_ready=0 in DONE.
- ERR: err=1, sticky.
  - All strobes are 0; in_ready=0 and out_valid=0.
  - Only rst exits ERR.
- Latency with a healthy datapath (tc on the 32nd ITER cycle):
  - Acceptance edge is E0; ITER occupies edges E3..E34; out_valid rises at edge E36.
  - A new operand pair can be accepted no earlier than 1 cycle after the out handshake.
- All strobes are Moore outputs decoded from state only; no strobe depends combinationally on tc.
- The watchdog count clears on entry to CLEAR.
- tc is ignored outside ITER.
- in_valid is ignored outside IDLE.
- Reset mid-operation:
  - Immediately returns the controller to reset values.
  - The datapath is re-cleared by the next CLEAR; no partial result is ever signalled.

Optional Feature:
- Macro MULT_CU_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in CLEAR, LOADM, FIRST, ITER or FINAL sends the next state to IDLE.
  - All strobes are 0 from the next cycle; no out_valid is produced.
  - If abort and tc coincide in ITER, abort wins.
  - abort in IDLE, DONE or ERR has no effect.
- Undefined: the abort port is absent and behaviour is exactly as above.

Test Plan:
- Signed multiply: in_a=-3, in_b=7, usigned=0, out_ready=1, datapath with tc on the 32nd ITER cycle.
  - Strobe sequence is CLEAR/LOADM/FIRST/32xITER/FINAL.
  - out_valid rises 36 cycles after acceptance.
  - Datapath product is 0xFFFF_FFFF_FFFF_FFEB.
- Unsigned multiply: in_a=0xFFFFFFFF, in_b=0xFFFFFFFF, usigned=1.
  - product is 0xFFFF_FFFE_0000_0001.
  - multiplier, multiplicand and usigned outputs stay constant throughout.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - out_valid is held and in_ready stays 0.
  - out_ready=1 moves the controller to IDLE with in_ready=1 the next cycle.
- Watchdog: tc tied to 0.
  - After MAX_ITER=40 ITER cycles, err=1 and all strobes are 0.
  - The controller stays in ERR until rst.
- Reset mid-operation: assert rst during the 10th ITER cycle.
  - All outputs are 0 asynchronously.
  - After release, a new operation 5x6 completes with product 30.
- With MULT_CU_ABORT_EN: abort in the 5th ITER cycle.
  - IDLE the next cycle and out_valid is never asserted.
  - The following 2x2 operation gives 4.
